// File: rtl/apb_master_pkg.sv
// Shared types and default widths for the APB master bridge.
package apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int unsigned DEF_ADDR_WIDTH     = 32;
  localparam int unsigned DEF_DATA_WIDTH     = 32;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/apb_master_wdog.sv
// Wait-state watchdog for the APB master: counts stalled ACCESS cycles and
// flags the cycle on which the count would reach the limit.
module apb_master_wdog #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic [WIDTH-1:0] limit,
  output logic             expired
);

  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] count_next;

  assign count_next = count + 1'b1;
  assign expired    = inc && (count_next == limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !expired) begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB3 initiator: valid/ready command in, valid/ready response out.
// Define APB_MASTER_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES stalled cycles.
module apb_master_bridge
  import apb_master_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                  pclk,
  input  logic                  hrst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  psel,
  output logic                  penable,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr
);

  apb_state_e state;
  apb_state_e next_state;
  logic       timeout;
  logic       access_done;

`ifdef APB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  apb_master_wdog #(
    .WIDTH (TW)
  ) u_wdog (
    .clk     (pclk),
    .rst     (hrst),
    .clr     (state == SETUP),
    .inc     ((state == ACCESS) && !pready),
    .limit   (TW'(TIMEOUT_CYCLES)),
    .expired (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Bus controls decode straight from state so reset drops them without a clock.
  assign cmd_ready   = (state == IDLE);
  assign psel        = (state == SETUP) || (state == ACCESS);
  assign penable     = (state == ACCESS);
  assign rsp_valid   = (state == RESP);
  assign access_done = (state == ACCESS) && (pready || timeout);

  always_ff @(posedge pclk or posedge hrst) begin
    if (hrst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:   if (cmd_valid)   next_state = SETUP;
      SETUP:                   next_state = ACCESS;
      ACCESS: if (access_done) next_state = RESP;
      RESP:   if (rsp_ready)   next_state = IDLE;
      default:                 next_state = IDLE;
    endcase
  end

  // Address/data are left at their last values between transfers to limit bus toggling.
  always_ff @(posedge pclk or posedge hrst) begin
    if (hrst) begin
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if ((state == IDLE) && cmd_valid) begin
        paddr  <= cmd_addr;
        pwrite <= cmd_write;
        pwdata <= cmd_wdata;
      end
      if (access_done) begin
        rsp_rdata <= (pready && !pwrite) ? prdata : '0;
        rsp_err   <= pready ? pslverr : 1'b1;
      end
    end
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Single-outstanding APB3 initiator that drives the register slaves on the peripheral bus (the CSR blocks).
- Converts a valid/ready command stream from the control sequencer or debug port into APB SETUP/ACCESS phases.
- Returns each read or write result on a valid/ready response channel.
- Lives in the pclk domain next to the CSR slaves.

Parameters:
- ADDR_WIDTH, 32, width of cmd_addr/paddr.
- DATA_WIDTH, 32, width of data buses.
- TIMEOUT_CYCLES, 255, maximum pready-low cycles in ACCESS before abort. Used only with APB_MASTER_TIMEOUT_EN.

Ports:
- pclk  in  1  bus clock; the only clock.
- hrst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_addr  in  ADDR_WIDTH  target byte address.
- cmd_write  in  1  1=write, 0=read.
- cmd_wdata  in  DATA_WIDTH  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when rsp_valid & rsp_ready.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_err  out  1  pslverr or timeout.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- paddr  out  ADDR_WIDTH  APB address.
- pwrite  out  1  APB direction.
- pwdata  out  DATA_WIDTH  APB write data.
- pready  in  1  slave ready.
- prdata  in  DATA_WIDTH  slave read data.
- pslverr  in  1  slave error.

Behaviour:
- Reset (hrst high, asynchronous): state IDLE. psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata and rsp_err all 0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- cmd_ready = (state==IDLE). Purely combinational from state; no dependence on cmd_valid.
- IDLE: on a handshake, register cmd_addr, cmd_write and cmd_wdata into paddr, pwrite and pwdata, then go to SETUP.
- SETUP: psel=1, penable=0. Unconditionally go to ACCESS next cycle.
- ACCESS: psel=1, penable=1. paddr, pwrite and pwdata are held stable. Stay while pready=0.
- ACCESS with pready=1:
  - capture rsp_rdata = pwrite ? 0 : prdata, and rsp_err = pslverr;
  - set rsp_valid=1, drop psel/penable, go to RESP.
- RESP: hold rsp_valid and response fields until rsp_ready=1, then clear rsp_valid and go to IDLE.
  - rsp_ready already high on the first RESP cycle still gives one RESP cycle.
- paddr, pwrite and pwdata keep their last values outside transfers. They are not zeroed, to reduce bus toggling.
- Latency with a zero-wait slave:
  - handshake at cycle 0;
  - SETUP at cycle 1;
  - ACCESS at cycle 2;
  - rsp_valid at cycle 3;
  - next cmd_ready earliest at cycle 4 if rsp_ready is high at cycle 3.
  - Each pready wait state adds 1 cycle.
- pready and pslverr are ignored outside ACCESS.
- Reset asserted mid-transfer: psel and penable drop immediately. No response is produced and the in-flight command is lost.
- cmd_* inputs may change freely while cmd_ready=0.

Optional Feature:
- Macro: APB_MASTER_TIMEOUT_EN.
- With the macro:
  - a counter of width $clog2(TIMEOUT_CYCLES+1) clears on SETUP and increments each ACCESS cycle with pready=0;
  - when the count reaches TIMEOUT_CYCLES with pready still 0, the transfer aborts: psel and penable drop, RESP is entered with rsp_err=1 and rsp_rdata=0;
  - pready=1 on the same cycle the limit is reached wins, giving a normal completion.
- Without the macro: ACCESS waits indefinitely, no counter logic exists, and TIMEOUT_CYCLES is unused.

Decomposition:
- Package apb_master_pkg holds:
  - the state enum typedef (IDLE, SETUP, ACCESS, RESP);
  - the default width constants.
- One sub-module, apb_master_wdog: the timeout counter with inputs clr/inc/limit and output expired. It is instantiated only under APB_MASTER_TIMEOUT_EN.
- FSM and datapath stay in apb_master_bridge.

Test Plan:
- Write, zero-wait: cmd_addr=0x04, cmd_wdata=0xC2, rsp_ready=1 -> psel cycle 1, penable cycle 2, pwdata=0xC2, rsp_valid cycle 3, rsp_err=0, rsp_rdata=0, cmd_ready high cycle 4.
- Read with waits: addr 0x100, pready low 3 ACCESS cycles, prdata=0x00000F11 -> penable high 4 cycles, rsp_rdata=0xF11, rsp_err=0.
- Slave error: read 0x200 with pslverr=1 while pready=1 -> rsp_err=1, rsp_rdata=prdata value, FSM returns to IDLE.
- Response backpressure: rsp_ready=0 for 5 cycles after rsp_valid -> rsp fields stable, cmd_ready=0 and psel=0 throughout, cmd_ready rises the cycle after rsp_ready=1.
- Timeout (macro on, TIMEOUT_CYCLES=8): pready held 0 -> abort after 8 ACCESS cycles with rsp_err=1 and rsp_rdata=0. Repeat with pready=1 on cycle 8 -> normal completion, rsp_err=0.
- Reset mid-ACCESS: hrst pulses during a wait state -> psel/penable/rsp_valid 0 asynchronously, state IDLE, and the next command completes normally.
